// File: rtl/axi_master_burst_ctrl_pkg.sv
// Shared AXI lab definitions: FSM state codes, response and burst encodings, bus widths.
package axi_lab_pkg;

  localparam int ID_W   = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int STRB_W = DATA_W / 8;
  localparam int RESP_W = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_ADDR = 3'd1;
  localparam logic [2:0] ST_WR_DATA = 3'd2;
  localparam logic [2:0] ST_WR_RESP = 3'd3;
  localparam logic [2:0] ST_RD_ADDR = 3'd4;
  localparam logic [2:0] ST_RD_DATA = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Response severity follows the numeric encoding, so "worst" is a plain max.
  function automatic logic [RESP_W-1:0] resp_max(input logic [RESP_W-1:0] a,
                                                 input logic [RESP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_master_burst_ctrl_if.sv
// Full MASTER_* AXI4 port of the lab interconnect; master drives address/write data, slave drives responses.
interface axi_master_burst_ctrl_if;
  import axi_lab_pkg::*;

  logic              master_clk;
  logic              master_rstn;

  logic [ID_W-1:0]   wr_addr_id;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  wr_addr_len;
  logic [1:0]        wr_addr_burst;
  logic              wr_addr_valid;
  logic              wr_addr_ready;

  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_data_strb;
  logic              wr_data_last;
  logic              wr_data_valid;
  logic              wr_data_ready;

  logic [ID_W-1:0]   wr_back_id;
  logic [RESP_W-1:0] wr_back_resp;
  logic              wr_back_valid;
  logic              wr_back_ready;

  logic [ID_W-1:0]   rd_addr_id;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_addr_len;
  logic [1:0]        rd_addr_burst;
  logic              rd_addr_valid;
  logic              rd_addr_ready;

  logic [ID_W-1:0]   rd_data_id;
  logic [DATA_W-1:0] rd_data;
  logic [RESP_W-1:0] rd_data_resp;
  logic              rd_data_last;
  logic              rd_data_valid;
  logic              rd_data_ready;

  modport master (
    output master_clk, master_rstn,
    output wr_addr_id, wr_addr, wr_addr_len, wr_addr_burst, wr_addr_valid,
    input  wr_addr_ready,
    output wr_data, wr_data_strb, wr_data_last, wr_data_valid,
    input  wr_data_ready,
    input  wr_back_id, wr_back_resp, wr_back_valid,
    output wr_back_ready,
    output rd_addr_id, rd_addr, rd_addr_len, rd_addr_burst, rd_addr_valid,
    input  rd_addr_ready,
    input  rd_data_id, rd_data, rd_data_resp, rd_data_last, rd_data_valid,
    output rd_data_ready
  );

  modport slave (
    input  master_clk, master_rstn,
    input  wr_addr_id, wr_addr, wr_addr_len, wr_addr_burst, wr_addr_valid,
    output wr_addr_ready,
    input  wr_data, wr_data_strb, wr_data_last, wr_data_valid,
    output wr_data_ready,
    output wr_back_id, wr_back_resp, wr_back_valid,
    input  wr_back_ready,
    input  rd_addr_id, rd_addr, rd_addr_len, rd_addr_burst, rd_addr_valid,
    output rd_addr_ready,
    output rd_data_id, rd_data, rd_data_resp, rd_data_last, rd_data_valid,
    input  rd_data_ready
  );

endinterface

// File: rtl/axi_master_burst_ctrl.sv
// One-at-a-time AXI4 burst master: address, then data (pass-through stream), then response; one done pulse per command.
// Minimum write latency cmd->done is 4 cycles; all stalls come from slave READY/VALID or the local streams.
module axi_master_burst_ctrl
  import axi_lab_pkg::*;
#(
  parameter logic [ID_W-1:0] ID    = 2'b00,
  parameter logic [1:0]      BURST = BURST_INCR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_write,
  input  logic [ADDR_W-1:0]   i_cmd_addr,
  input  logic [LEN_W-1:0]    i_cmd_len,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic [STRB_W-1:0]   i_wr_strb,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  output logic [DATA_W-1:0]   o_rd_data,
  output logic                o_rd_last,
  output logic                o_rd_valid,
  input  logic                i_rd_ready,
  output logic                o_done_valid,
  output logic [RESP_W-1:0]   o_done_resp,
  output logic                o_busy,
  axi_master_burst_ctrl_if.master m
);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic              r_addr_valid;
  logic [LEN_W-1:0]  r_beat;
  logic [RESP_W-1:0] r_acc;

  logic              w_wr_last;
  logic              w_wr_hs;
  logic              w_rd_hs;
  logic [RESP_W-1:0] w_b_resp;
  logic [RESP_W-1:0] w_rd_resp;

  assign w_wr_last = (r_beat == r_len);
  assign w_wr_hs   = (r_state == ST_WR_DATA) && i_wr_valid && m.wr_data_ready;
  assign w_rd_hs   = (r_state == ST_RD_DATA) && m.rd_data_valid && i_rd_ready;
  assign w_b_resp  = resp_max(m.wr_back_resp,
                              (m.wr_back_id != ID) ? RESP_SLVERR : RESP_OKAY);
  // A misplaced RLAST or a foreign ID is reported as at least SLVERR.
  assign w_rd_resp = resp_max(m.rd_data_resp,
                              ((m.rd_data_id != ID) || (m.rd_data_last && (r_beat != r_len)))
                              ? RESP_SLVERR : RESP_OKAY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_addr_valid <= 1'b0;
      r_beat       <= '0;
      r_acc        <= RESP_OKAY;
    end else begin
      case (r_state)
        ST_IDLE: if (i_cmd_valid) begin
          r_addr       <= i_cmd_addr;
          r_len        <= i_cmd_len;
          r_beat       <= '0;
          r_acc        <= RESP_OKAY;
          r_addr_valid <= 1'b1;
          r_state      <= i_cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
        end
        ST_WR_ADDR: if (m.wr_addr_ready) begin
          r_addr_valid <= 1'b0;
          r_state      <= ST_WR_DATA;
        end
        ST_RD_ADDR: if (m.rd_addr_ready) begin
          r_addr_valid <= 1'b0;
          r_state      <= ST_RD_DATA;
        end
        ST_WR_DATA: if (w_wr_hs) begin
          if (w_wr_last) r_state <= ST_WR_RESP;
          else           r_beat  <= r_beat + 8'd1;
        end
        ST_WR_RESP: if (m.wr_back_valid) begin
          r_acc   <= resp_max(r_acc, w_b_resp);
          r_state <= ST_DONE;
        end
        ST_RD_DATA: if (w_rd_hs) begin
          r_acc <= resp_max(r_acc, w_rd_resp);
          // Overlong bursts keep draining; the counter parks at 255 instead of wrapping.
          if (r_beat != 8'hFF) r_beat <= r_beat + 8'd1;
          if (m.rd_data_last)  r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m.master_clk    = clk;
  assign m.master_rstn   = ~rst;

  assign m.wr_addr_id    = ID;
  assign m.wr_addr       = r_addr;
  assign m.wr_addr_len   = r_len;
  assign m.wr_addr_burst = BURST;
  assign m.wr_addr_valid = r_addr_valid && (r_state == ST_WR_ADDR);

  assign m.rd_addr_id    = ID;
  assign m.rd_addr       = r_addr;
  assign m.rd_addr_len   = r_len;
  assign m.rd_addr_burst = BURST;
  assign m.rd_addr_valid = r_addr_valid && (r_state == ST_RD_ADDR);

  assign m.wr_data       = i_wr_data;
  assign m.wr_data_strb  = i_wr_strb;
  assign m.wr_data_last  = (r_state == ST_WR_DATA) && w_wr_last;
  assign m.wr_data_valid = (r_state == ST_WR_DATA) && i_wr_valid;
  assign o_wr_ready      = (r_state == ST_WR_DATA) && m.wr_data_ready;

  assign m.wr_back_ready = (r_state == ST_WR_RESP);

  assign o_rd_data       = m.rd_data;
  assign o_rd_last       = m.rd_data_last;
  assign o_rd_valid      = (r_state == ST_RD_DATA) && m.rd_data_valid;
  assign m.rd_data_ready = (r_state == ST_RD_DATA) && i_rd_ready;

  assign o_cmd_ready     = (r_state == ST_IDLE);
  assign o_busy          = (r_state != ST_IDLE);
  assign o_done_valid    = (r_state == ST_DONE);
  assign o_done_resp     = (r_state == ST_DONE) ? r_acc : RESP_OKAY;

endmodule

// File: tb/tb_axi_master_burst_ctrl.sv
// Randomised bench for axi_master_burst_ctrl: bench plays command source, stream ends and AXI slave, with a transaction-level model.
module tb_axi_master_burst_ctrl;
  import axi_lab_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [31:0] i_cmd_addr;
  logic [7:0]  i_cmd_len;
  logic [31:0] i_wr_data;
  logic [3:0]  i_wr_strb;
  logic        i_wr_valid, o_wr_ready;
  logic [31:0] o_rd_data;
  logic        o_rd_last, o_rd_valid, i_rd_ready;
  logic        o_done_valid;
  logic [1:0]  o_done_resp;
  logic        o_busy;

  axi_master_burst_ctrl_if m();

  axi_master_burst_ctrl dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_wr_data(i_wr_data), .i_wr_strb(i_wr_strb), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .o_rd_data(o_rd_data), .o_rd_last(o_rd_last), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
    .o_done_valid(o_done_valid), .o_done_resp(o_done_resp), .o_busy(o_busy),
    .m(m)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction configuration and the slave's planned read beats.
  bit          c_wr;
  logic [31:0] c_addr;
  logic [7:0]  c_len;
  int          c_adly, c_bdly, c_gap, c_rdy, c_abort;
  logic [1:0]  c_bresp, c_bid;
  bit          c_lat;
  int          n_beats;
  logic [31:0] rb_data[$];
  logic [1:0]  rb_resp[$];
  logic [1:0]  rb_id[$];
  logic [1:0]  last_resp;
  int          last_beats;

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Expected completion status from the transaction as a whole.
  function automatic logic [1:0] model_resp();
    logic [1:0] e = 2'b00;
    if (c_wr) begin
      e = c_bresp;
      if (c_bid != 2'b00) e = worst(e, 2'b10);
    end else begin
      for (int i = 0; i < n_beats; i++) begin
        e = worst(e, rb_resp[i]);
        if (rb_id[i] != 2'b00) e = worst(e, 2'b10);
      end
      if (n_beats - 1 != int'(c_len)) e = worst(e, 2'b10);
    end
    return e;
  endfunction

  task automatic set_cfg(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                         input int adly, input int bdly, input int gap, input int rdy,
                         input logic [1:0] bresp, input logic [1:0] bid);
    c_wr = wr; c_addr = addr; c_len = len; c_adly = adly; c_bdly = bdly;
    c_gap = gap; c_rdy = rdy; c_bresp = bresp; c_bid = bid; c_abort = -1; c_lat = 0;
  endtask

  task automatic plan_read(input int n, input int rmax, input int bad_id_beat);
    rb_data.delete(); rb_resp.delete(); rb_id.delete();
    n_beats = n;
    for (int i = 0; i < n; i++) begin
      rb_data.push_back($urandom);
      rb_resp.push_back(2'($urandom_range(rmax)));
      rb_id.push_back((i == bad_id_beat) ? 2'b01 : 2'b00);
    end
  endtask

  task automatic clear_inputs();
    i_cmd_valid = 0; i_wr_valid = 0; i_rd_ready = 0;
    m.wr_addr_ready = 0; m.rd_addr_ready = 0; m.wr_data_ready = 0;
    m.wr_back_valid = 0; m.rd_data_valid = 0; m.rd_data_last = 0;
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("busy_vs_cmd_ready", o_busy, !o_cmd_ready);
    chk("single_addr_valid", m.wr_addr_valid & m.rd_addr_valid, 0);
    chk("master_rstn", m.master_rstn, !rst);
  end

  // Called at posedge+1; returns at posedge+1. ph: 0 cmd, 1 addr, 2 data, 3 B, 4 done, 5 finished.
  task automatic run_txn();
    int ph = 0, oldph, cnt = 0, wbeat = 0, k = 0, cyc = 0, t_acc = 0;
    bit need_new = 1, rneed = 1;
    logic [1:0] exp_resp;
    exp_resp = model_resp();
    while (ph != 5) begin
      i_cmd_valid = (ph == 0);
      i_cmd_write = c_wr; i_cmd_addr = c_addr; i_cmd_len = c_len;
      m.wr_addr_ready = (ph == 1) && c_wr && (cnt >= c_adly);
      m.rd_addr_ready = (ph == 1) && !c_wr && (cnt >= c_adly);
      if (ph == 2 && c_wr) begin
        if (!i_wr_valid || need_new) begin
          i_wr_valid = ($urandom_range(99) >= c_gap);
          i_wr_data = $urandom; i_wr_strb = 4'($urandom); need_new = 0;
        end
        m.wr_data_ready = ($urandom_range(99) < c_rdy);
      end else begin
        i_wr_valid = 0; m.wr_data_ready = 0;
      end
      m.wr_back_valid = (ph == 3) && (cnt >= c_bdly);
      m.wr_back_resp = c_bresp; m.wr_back_id = c_bid;
      if (ph == 2 && !c_wr) begin
        if (!m.rd_data_valid || rneed) begin
          rneed = 0;
          if (k < n_beats) begin
            m.rd_data_valid = ($urandom_range(99) >= c_gap);
            m.rd_data = rb_data[k]; m.rd_data_resp = rb_resp[k];
            m.rd_data_id = rb_id[k]; m.rd_data_last = (k == n_beats - 1);
          end else m.rd_data_valid = 0;
        end
        i_rd_ready = ($urandom_range(99) < c_rdy);
      end else begin
        m.rd_data_valid = 0; i_rd_ready = 0;
      end
      if (ph == 2 && !c_wr && k == c_abort) rst = 1;

      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rstn_low_in_reset", m.master_rstn, 0);
        @(posedge clk); #1;
        rst = 0;
        i_wr_valid = 1; i_rd_ready = 1; m.rd_data_valid = 1; m.wr_data_ready = 1;
        m.wr_addr_ready = 1; m.rd_addr_ready = 1; m.wr_back_valid = 1;
        @(negedge clk);
        chk("abort_wr_addr_valid", m.wr_addr_valid, 0);
        chk("abort_rd_addr_valid", m.rd_addr_valid, 0);
        chk("abort_wr_data_valid", m.wr_data_valid, 0);
        chk("abort_wr_ready", o_wr_ready, 0);
        chk("abort_bready", m.wr_back_ready, 0);
        chk("abort_rd_valid", o_rd_valid, 0);
        chk("abort_rd_data_ready", m.rd_data_ready, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_cmd_ready", o_cmd_ready, 1);
        chk("abort_done_valid", o_done_valid, 0);
        @(posedge clk); #1;
        clear_inputs();
        return;
      end
      oldph = ph;
      case (ph)
        0: begin
          chk("cmd_ready_idle", o_cmd_ready, 1);
          if (o_cmd_ready) begin ph = 1; t_acc = cyc; end
        end
        1: begin
          if (c_wr) begin
            chk("wr_addr_valid", m.wr_addr_valid, 1);
            chk("wr_addr", m.wr_addr, c_addr);
            chk("wr_addr_len", m.wr_addr_len, c_len);
            chk("wr_addr_id", m.wr_addr_id, 0);
            chk("wr_addr_burst", m.wr_addr_burst, 1);
            if (m.wr_addr_valid && m.wr_addr_ready) ph = 2;
          end else begin
            chk("rd_addr_valid", m.rd_addr_valid, 1);
            chk("rd_addr", m.rd_addr, c_addr);
            chk("rd_addr_len", m.rd_addr_len, c_len);
            chk("rd_addr_id", m.rd_addr_id, 0);
            chk("rd_addr_burst", m.rd_addr_burst, 1);
            if (m.rd_addr_valid && m.rd_addr_ready) ph = 2;
          end
        end
        2: if (c_wr) begin
          chk("wvalid_pass", m.wr_data_valid, i_wr_valid);
          chk("wready_pass", o_wr_ready, m.wr_data_ready);
          chk("bready_early", m.wr_back_ready, 0);
          if (i_wr_valid) begin
            chk("wdata_pass", m.wr_data, i_wr_data);
            chk("wstrb_pass", m.wr_data_strb, i_wr_strb);
            chk("wlast", m.wr_data_last, wbeat == int'(c_len));
            if (m.wr_data_ready) begin
              need_new = 1;
              if (wbeat == int'(c_len)) ph = 3;
              wbeat++;
            end
          end
        end else begin
          chk("rvalid_pass", o_rd_valid, m.rd_data_valid);
          chk("rready_pass", m.rd_data_ready, i_rd_ready);
          if (m.rd_data_valid) begin
            chk("rdata_order", o_rd_data, rb_data[k]);
            chk("rlast", o_rd_last, k == n_beats - 1);
            if (i_rd_ready) begin
              rneed = 1; k++;
              if (k == n_beats) ph = 4;
            end
          end
        end
        3: begin
          chk("bready", m.wr_back_ready, 1);
          if (m.wr_back_valid) ph = 4;
        end
        default: begin
          chk("done_valid", o_done_valid, 1);
          chk("done_resp", o_done_resp, exp_resp);
          if (c_lat) chk("write_latency", cyc - t_acc, 4);
          last_resp = o_done_resp;
          last_beats = c_wr ? wbeat : k;
          ph = 5;
        end
      endcase
      cnt = (ph != oldph) ? 0 : cnt + 1;
      if (cyc > 4000) begin
        total++; bad++;
        $display("FAIL txn_timeout: stuck in phase %0d after %0d cycles, want done", ph, cyc);
        @(posedge clk); #1; rst = 1; clear_inputs();
        @(posedge clk); #1; rst = 0;
        return;
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    @(negedge clk);
    chk("done_one_cycle", o_done_valid, 0);
    chk("cmd_ready_after_done", o_cmd_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; i_cmd_write = 0; i_cmd_addr = 0; i_cmd_len = 0; i_wr_data = 0; i_wr_strb = 0;
    clear_inputs();
    i_wr_valid = 1; i_rd_ready = 1; m.rd_data_valid = 1; m.wr_data_ready = 1;
    m.wr_back_valid = 1; m.wr_back_resp = 0; m.wr_back_id = 0;
    m.rd_data = 0; m.rd_data_resp = 0; m.rd_data_id = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done_valid", o_done_valid, 0);
    chk("rst_wr_addr_valid", m.wr_addr_valid, 0);
    chk("rst_rd_addr_valid", m.rd_addr_valid, 0);
    chk("rst_wr_data_valid", m.wr_data_valid, 0);
    chk("rst_wr_ready", o_wr_ready, 0);
    chk("rst_bready", m.wr_back_ready, 0);
    chk("rst_rd_valid", o_rd_valid, 0);
    chk("rst_rd_data_ready", m.rd_data_ready, 0);
    chk("rst_addr", m.wr_addr, 0);
    chk("rst_len", m.rd_addr_len, 0);
    chk("rst_rstn", m.master_rstn, 0);
    @(posedge clk); #1;
    rst = 0; clear_inputs(); chk_on = 1;

    set_cfg(1, 32'h1000, 8'd3, 0, 0, 0, 100, 2'b00, 2'b00);
    run_txn();
    chk("t1_resp_okay", last_resp, 2'b00);
    chk("t1_beats", last_beats, 4);

    set_cfg(0, 32'h2000, 8'd7, 0, 2, 40, 50, 2'b00, 2'b00);
    plan_read(8, 0, -1);
    run_txn();
    chk("t2_beats", last_beats, 8);
    chk("t2_resp_okay", last_resp, 2'b00);

    set_cfg(0, 32'h3000, 8'd3, 1, 0, 0, 100, 2'b00, 2'b00);
    plan_read(2, 0, -1);
    run_txn();
    chk("t3_early_last_beats", last_beats, 2);
    chk("t3_early_last_resp", last_resp, 2'b10);

    set_cfg(1, 32'h4000, 8'd0, 5, 1, 0, 100, 2'b10, 2'b00);
    run_txn();
    chk("t4_slverr", last_resp, 2'b10);
    chk("t4_beats", last_beats, 1);

    set_cfg(0, 32'h5000, 8'd3, 0, 0, 0, 100, 2'b00, 2'b00);
    plan_read(4, 0, -1);
    c_abort = 1;
    run_txn();
    set_cfg(1, 32'h5100, 8'd1, 0, 0, 0, 100, 2'b00, 2'b00);
    run_txn();
    chk("t5_after_reset_resp", last_resp, 2'b00);
    chk("t5_after_reset_beats", last_beats, 2);

    set_cfg(1, 32'h6000, 8'd2, 0, 1, 20, 70, 2'b00, 2'b01);
    run_txn();
    chk("t6_bad_bid", last_resp, 2'b10);

    set_cfg(1, 32'h7000, 8'd0, 0, 0, 0, 100, 2'b01, 2'b00);
    c_lat = 1;
    run_txn();
    chk("t7_exokay", last_resp, 2'b01);

    set_cfg(0, 32'h8000, 8'd2, 0, 0, 10, 80, 2'b00, 2'b00);
    plan_read(6, 0, -1);
    run_txn();
    chk("t8_late_last_beats", last_beats, 6);
    chk("t8_late_last_resp", last_resp, 2'b10);

    set_cfg(0, 32'h9000, 8'd0, 0, 0, 0, 100, 2'b00, 2'b00);
    plan_read(1, 0, 0);
    run_txn();
    chk("t9_bad_rid", last_resp, 2'b10);

    set_cfg(1, 32'hA000, 8'd255, 0, 0, 10, 90, 2'b00, 2'b00);
    run_txn();
    chk("t10_wr256_beats", last_beats, 256);
    set_cfg(0, 32'hB000, 8'd255, 0, 0, 10, 90, 2'b00, 2'b00);
    plan_read(256, 0, -1);
    run_txn();
    chk("t10_rd256_beats", last_beats, 256);
    chk("t10_rd256_resp", last_resp, 2'b00);

    for (int t = 0; t < 24; t++) begin
      int len, n, r;
      len = $urandom_range(15);
      set_cfg($urandom_range(1), $urandom, 8'(len), $urandom_range(3), $urandom_range(3),
              $urandom_range(50), $urandom_range(100, 30), 2'($urandom_range(3)),
              ($urandom_range(9) == 0) ? 2'b01 : 2'b00);
      if (!c_wr) begin
        r = $urandom_range(9);
        n = len + 1;
        if (r == 0 && len > 0) n = $urandom_range(len, 1);
        if (r == 1) n = len + 1 + $urandom_range(3, 1);
        plan_read(n, $urandom_range(3), ($urandom_range(9) == 0) ? $urandom_range(n - 1) : -1);
      end
      run_txn();
    end

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
